mm_seq_ctrl: RTL and testbench

MM_SEQ_CTRL -- requirements
Module: mm_seq_ctrl

---
 rtl/mm_pkg.sv | 24 ++
 rtl/mm_valid_pipe.sv | 53 +++++
 rtl/mm_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mm_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared encodings for the matrix-multiply sequencer.
// Mode values and FSM states used by mm_seq_ctrl and its bench.
package mm_pkg;

    typedef enum logic [1:0] {
        MODE_INT8     = 2'd0,
        MODE_INT4     = 2'd1,
        MODE_INT4_VSQ = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCALE = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic mode_ok(input logic [1:0] mode);
        return mode != MODE_RSVD;
    endfunction

endpackage

// File: rtl/mm_valid_pipe.sv
// mm_valid_pipe: stall-able, flushable delay line that carries the
// accumulator enable, clear and address from read issue to write.
module mm_valid_pipe #(
    parameter int PIPE   = 3,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_en,
    input  logic              in_clr,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_en,
    output logic              out_clr,
    output logic [ADDR_W-1:0] out_addr
);

    logic [PIPE-1:0]   en_q;
    logic [PIPE-1:0]   clr_q;
    logic [ADDR_W-1:0] addr_q [PIPE];

    // Shift one stage per unstalled cycle; flush kills every beat in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q  <= '0;
            clr_q <= '0;
            for (int i = 0; i < PIPE; i++) begin
                addr_q[i] <= '0;
            end
        end else if (flush) begin
            en_q  <= '0;
            clr_q <= '0;
        end else if (!stall) begin
            for (int i = PIPE - 1; i > 0; i--) begin
                en_q[i]   <= en_q[i-1];
                clr_q[i]  <= clr_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
            en_q[0]   <= in_en;
            clr_q[0]  <= in_clr;
            addr_q[0] <= in_addr;
        end
    end

    // A stalled or aborted cycle must never write the accumulator.
    always_comb begin
        out_en   = en_q[PIPE-1] & ~stall & ~flush;
        out_clr  = clr_q[PIPE-1] & ~stall & ~flush;
        out_addr = addr_q[PIPE-1];
    end

endmodule

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: walks an M x N x K tiled matmul, issuing A/B (and VSQ
// scale) reads and the delayed accumulator write controls.
module mm_seq_ctrl
    import mm_pkg::*;
#(
    parameter int DIM_W  = 6,
    parameter int ADDR_W = 10,
    parameter int PIPE   = 3,
    parameter int VSQ_G  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_mode,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_stall,
    input  logic [DIM_W-1:0]  i_m,
    input  logic [DIM_W-1:0]  i_n,
    input  logic [DIM_W-1:0]  i_k,
    output logic              o_a_ren,
    output logic [ADDR_W-1:0] o_a_addr,
    output logic              o_b_ren,
    output logic [ADDR_W-1:0] o_b_addr,
    output logic              o_s_ren,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic              o_acc_en,
    output logic              o_acc_clr,
    output logic [ADDR_W-1:0] o_acc_addr,
    output logic [1:0]        o_mode,
    output logic              o_busy,
    output logic              o_done
);

    localparam int SH = $clog2(VSQ_G);
    localparam int CW = $clog2(PIPE) + 1;
    localparam logic [DIM_W-1:0] D_ONE = DIM_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [DIM_W-1:0] GMASK = DIM_W'(VSQ_G - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE - 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    state_e            state;
    mode_e             mode_q;
    logic [DIM_W-1:0]  m_dim;
    logic [DIM_W-1:0]  n_dim;
    logic [DIM_W-1:0]  ke;
    logic [DIM_W-1:0]  m_cnt;
    logic [DIM_W-1:0]  n_cnt;
    logic [DIM_W-1:0]  k_cnt;
    logic [ADDR_W-1:0] a_row;
    logic [ADDR_W-1:0] b_row;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] acc_cur;
    logic [CW-1:0]     drain_cnt;

    logic [DIM_W:0]    k_inc;
    logic [DIM_W-1:0]  ke_in;
    logic [DIM_W-1:0]  k_next;
    logic [ADDR_W-1:0] ke_a;
    logic              accept;
    logic              zero_dim;
    logic              go;
    logic              rd;
    logic              s_rd;
    logic              clr_in;
    logic              last_k;
    logic              last_n;
    logic              last_m;
    logic              need_scale;

    // Two 4-bit values share a word, so packed modes walk ceil(K/2) steps.
    always_comb begin
        k_inc      = {1'b0, i_k} + {{DIM_W{1'b0}}, 1'b1};
        ke_in      = (i_mode == MODE_INT8) ? i_k : k_inc[DIM_W:1];
        ke_a       = ADDR_W'(ke);
        accept     = i_start && !i_abort && mode_ok(i_mode) &&
                     (state == ST_IDLE || state == ST_DONE);
        zero_dim   = (i_m == '0) || (i_n == '0) || (i_k == '0);
        go         = !i_abort && !i_stall;
        rd         = (state == ST_ISSUE) && go;
        s_rd       = (state == ST_SCALE) && go;
        clr_in     = rd && (k_cnt == '0);
        last_k     = (k_cnt == ke - D_ONE);
        last_n     = (n_cnt == n_dim - D_ONE);
        last_m     = (m_cnt == m_dim - D_ONE);
        k_next     = last_k ? '0 : k_cnt + D_ONE;
        need_scale = (mode_q == MODE_INT4_VSQ) && ((k_next & GMASK) == '0);
    end

    // Sequencer FSM; addresses advance as running sums, never products.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_INT8;
            m_dim     <= '0;
            n_dim     <= '0;
            ke        <= '0;
            m_cnt     <= '0;
            n_cnt     <= '0;
            k_cnt     <= '0;
            a_row     <= '0;
            b_row     <= '0;
            a_addr    <= '0;
            b_addr    <= '0;
            acc_cur   <= '0;
            drain_cnt <= '0;
        end else if (i_abort) begin
            state <= ST_IDLE;
        end else if (!i_stall) begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        mode_q    <= mode_e'(i_mode);
                        m_dim     <= i_m;
                        n_dim     <= i_n;
                        ke        <= ke_in;
                        m_cnt     <= '0;
                        n_cnt     <= '0;
                        k_cnt     <= '0;
                        a_row     <= '0;
                        b_row     <= '0;
                        a_addr    <= '0;
                        b_addr    <= '0;
                        acc_cur   <= '0;
                        drain_cnt <= '0;
                        if (zero_dim) begin
                            state <= ST_DONE;
                        end else if (i_mode == MODE_INT4_VSQ) begin
                            state <= ST_SCALE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_SCALE: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    k_cnt <= k_next;
                    if (!last_k) begin
                        a_addr <= a_addr + A_ONE;
                        b_addr <= b_addr + A_ONE;
                        if (need_scale) state <= ST_SCALE;
                    end else if (!last_n) begin
                        n_cnt   <= n_cnt + D_ONE;
                        b_row   <= b_row + ke_a;
                        b_addr  <= b_row + ke_a;
                        a_addr  <= a_row;
                        acc_cur <= acc_cur + A_ONE;
                        if (need_scale) state <= ST_SCALE;
                    end else if (!last_m) begin
                        n_cnt   <= '0;
                        m_cnt   <= m_cnt + D_ONE;
                        a_row   <= a_row + ke_a;
                        a_addr  <= a_row + ke_a;
                        b_row   <= '0;
                        b_addr  <= '0;
                        acc_cur <= acc_cur + A_ONE;
                        if (need_scale) state <= ST_SCALE;
                    end else begin
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + C_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mm_valid_pipe #(
        .PIPE   (PIPE),
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .stall    (i_stall),
        .flush    (i_abort),
        .in_en    (rd),
        .in_clr   (clr_in),
        .in_addr  (acc_cur),
        .out_en   (o_acc_en),
        .out_clr  (o_acc_clr),
        .out_addr (o_acc_addr)
    );

    // Read strobes drop combinationally under stall; addresses just hold.
    always_comb begin
        o_a_ren  = rd;
        o_b_ren  = rd;
        o_a_addr = a_addr;
        o_b_addr = b_addr;
        o_s_ren  = s_rd;
        o_s_addr = a_addr >> SH;
        o_mode   = mode_q;
        o_busy   = (state == ST_SCALE) || (state == ST_ISSUE) ||
                   (state == ST_DRAIN);
        o_done   = (state == ST_DONE);
    end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: directed checks of the matmul sequencer with
// hand-computed address, strobe and timing expectations.
module tb_mm_seq_ctrl;

    localparam int DIM_W  = 6;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic              start;
    logic              abort;
    logic              stall;
    logic [DIM_W-1:0]  m_in;
    logic [DIM_W-1:0]  n_in;
    logic [DIM_W-1:0]  k_in;
    logic              a_ren;
    logic [ADDR_W-1:0] a_addr;
    logic              b_ren;
    logic [ADDR_W-1:0] b_addr;
    logic              s_ren;
    logic [ADDR_W-1:0] s_addr;
    logic              acc_en;
    logic              acc_clr;
    logic [ADDR_W-1:0] acc_addr;
    logic [1:0]        mode_out;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int s = 0;
    int done_at = -1;
    int rd_first = -1;
    int acc_first = -1;
    int issue_cyc = 0;
    int a_log[$];
    int b_log[$];
    int acc_log[$];
    int clr_log[$];
    int s_log[$];
    int s_cyc[$];

    always #5 clk = ~clk;

    mm_seq_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_mode     (mode),
        .i_start    (start),
        .i_abort    (abort),
        .i_stall    (stall),
        .i_m        (m_in),
        .i_n        (n_in),
        .i_k        (k_in),
        .o_a_ren    (a_ren),
        .o_a_addr   (a_addr),
        .o_b_ren    (b_ren),
        .o_b_addr   (b_addr),
        .o_s_ren    (s_ren),
        .o_s_addr   (s_addr),
        .o_acc_en   (acc_en),
        .o_acc_clr  (acc_clr),
        .o_acc_addr (acc_addr),
        .o_mode     (mode_out),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input int got[$],
                           input int exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        foreach (exp[i]) begin
            if (i < got.size()) begin
                chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_ren"}, a_ren, 0);
        chk({tag, "_b_ren"}, b_ren, 0);
        chk({tag, "_s_ren"}, s_ren, 0);
        chk({tag, "_acc_en"}, acc_en, 0);
        chk({tag, "_acc_clr"}, acc_clr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mode"}, mode_out, 0);
        chk({tag, "_a_addr"}, a_addr, 0);
        chk({tag, "_b_addr"}, b_addr, 0);
        chk({tag, "_s_addr"}, s_addr, 0);
        chk({tag, "_acc_addr"}, acc_addr, 0);
    endtask

    task automatic clear_logs();
        a_log.delete();
        b_log.delete();
        acc_log.delete();
        clr_log.delete();
        s_log.delete();
        s_cyc.delete();
        done_at = -1;
        rd_first = -1;
        acc_first = -1;
        issue_cyc = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (a_ren) begin
            a_log.push_back(int'(a_addr));
            b_log.push_back(int'(b_addr));
            if (rd_first < 0) rd_first = cyc;
        end
        if (s_ren) begin
            s_log.push_back(int'(s_addr));
            s_cyc.push_back(cyc);
        end
        if (a_ren || s_ren) issue_cyc++;
        if (acc_en) begin
            acc_log.push_back(int'(acc_addr));
            clr_log.push_back(int'(acc_clr));
            if (acc_first < 0) acc_first = cyc;
        end
        if (done && done_at < 0) done_at = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] md, input int m, input int n,
                            input int k);
        clear_logs();
        mode  = md;
        m_in  = DIM_W'(m);
        n_in  = DIM_W'(n);
        k_in  = DIM_W'(k);
        start = 1'b1;
        s     = cyc;
        step();
        start = 1'b0;
        done_at = -1;
    endtask

    initial begin
        int e[$];
        rst_n = 1'b0;
        mode  = 2'd0;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        m_in  = '0;
        n_in  = '0;
        k_in  = '0;
        step();
        step();
        rst_n = 1'b1;
        chk_zero("rst");

        // reserved mode is ignored
        do_start(2'd3, 1, 1, 1);
        chk("m3_busy", busy, 0);
        chk("m3_mode", mode_out, 0);

        // INT8 2x2x2
        do_start(2'd0, 2, 2, 2);
        repeat (14) step();
        e = '{0, 1, 0, 1, 2, 3, 2, 3};
        chk_seq("t1_a", a_log, e);
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_seq("t1_b", b_log, e);
        e = '{0, 0, 1, 1, 2, 2, 3, 3};
        chk_seq("t1_acc", acc_log, e);
        e = '{1, 0, 1, 0, 1, 0, 1, 0};
        chk_seq("t1_clr", clr_log, e);
        chk("t1_rd_lat", rd_first - s, 1);
        chk("t1_acc_lat", acc_first - s, 4);
        chk("t1_done_lat", done_at - s, 12);
        chk("t1_done_hold", done, 1);
        chk("t1_busy", busy, 0);

        // INT4 1x1x3 started from DONE
        do_start(2'd1, 1, 1, 3);
        chk("t2_done_drop", done, 0);
        repeat (8) step();
        e = '{0, 1};
        chk_seq("t2_a", a_log, e);
        e = '{1, 0};
        chk_seq("t2_clr", clr_log, e);
        chk("t2_done_lat", done_at - s, 6);
        chk("t2_mode", mode_out, 1);

        // INT4_VSQ 1x1x16
        do_start(2'd2, 1, 1, 16);
        repeat (16) step();
        e = '{0, 1};
        chk_seq("t3_s", s_log, e);
        e = '{s + 1, s + 6};
        chk_seq("t3_scyc", s_cyc, e);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_seq("t3_a", a_log, e);
        chk("t3_issue_cyc", issue_cyc, 10);
        chk("t3_done_lat", done_at - s, 14);
        chk("t3_mode", mode_out, 2);

        // INT8 2x2x2 with a 3-cycle stall and an ignored start
        do_start(2'd0, 2, 2, 2);
        step();
        step();
        stall = 1'b1;
        #1;
        chk("t4_stall_ren", a_ren, 0);
        chk("t4_stall_baddr", b_addr, 2);
        repeat (3) step();
        stall = 1'b0;
        step();
        step();
        start = 1'b1;
        m_in  = DIM_W'(3);
        step();
        start = 1'b0;
        repeat (14) step();
        e = '{0, 1, 0, 1, 2, 3, 2, 3};
        chk_seq("t4_a", a_log, e);
        e = '{0, 0, 1, 1, 2, 2, 3, 3};
        chk_seq("t4_acc", acc_log, e);
        chk("t4_done_lat", done_at - s, 15);

        // abort in DRAIN
        do_start(2'd0, 1, 1, 2);
        step();
        step();
        chk("t5_busy_drain", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (8) step();
        chk("t5_reads", a_log.size(), 2);
        chk("t5_acc_cnt", acc_log.size(), 0);
        chk("t5_done_seen", done_at, -1);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);

        // K=0
        do_start(2'd0, 4, 4, 0);
        repeat (3) step();
        chk("t6_done_lat", done_at - s, 1);
        chk("t6_reads", a_log.size(), 0);
        chk("t6_acc_cnt", acc_log.size(), 0);

        // synchronous reset mid-ISSUE
        do_start(2'd1, 2, 2, 4);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_zero("t7");
        clear_logs();
        repeat (10) step();
        chk("t7_reads", a_log.size(), 0);
        chk("t7_acc_cnt", acc_log.size(), 0);
        chk("t7_done_seen", done_at, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
